// File: rtl/flb_ctrl_pkg.sv
// rtl/flb_ctrl_pkg.sv - shared types and default timing for the FLB sequencer
//
// Contents:
//   CNT_W_DEF, T_*_DEF  default settle counter width and settle times (cycles)
//   flb_seq_state_e     sequencer state encoding (4 bits, exported on state_o)
//   flb_cfg_t           shadowed FLB configuration bundle
package flb_ctrl_pkg;

    localparam int CNT_W_DEF  = 8;
    localparam int T_FLB_DEF  = 4;
    localparam int T_SYNC_DEF = 8;
    localparam int T_SDM_DEF  = 4;
    localparam int T_DEC_DEF  = 2;
    localparam int T_DN_DEF   = 2;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_UP_FLB  = 4'd1,
        S_UP_SYNC = 4'd2,
        S_UP_SDM  = 4'd3,
        S_UP_DEC  = 4'd4,
        S_RUN     = 4'd5,
        S_DN_DEC  = 4'd6,
        S_DN_SDM  = 4'd7,
        S_DN_SYNC = 4'd8,
        S_DN_FLB  = 4'd9,
        S_APPLY   = 4'd10
    } flb_seq_state_e;

    typedef struct packed {
        logic [1:0] mtrx_lag;
        logic [1:0] smpl_lag;
        logic       sdm_order;
        logic       sdm_thrm_en;
    } flb_cfg_t;

endpackage

// File: rtl/flb_settle_timer.sv
// rtl/flb_settle_timer.sv - loadable down-counter used for per-state settle times
//
// Ports:
//   ref_clk   in   clock
//   rst       in   asynchronous active-high reset
//   load      in   load load_val this cycle (takes priority over counting)
//   load_val  in   value to load, CNT_W bits
//   expired   out  count has reached zero
module flb_settle_timer #(
    parameter int CNT_W = 8
) (
    input  logic             ref_clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] r_cnt;

    // Counts down and parks at zero, so expired stays high in states that
    // never reload the timer (IDLE, RUN).
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign expired = (r_cnt == '0);

endmodule

// File: rtl/flb_seq_ctrl.sv
// rtl/flb_seq_ctrl.sv - FLB power-up/power-down/reconfiguration sequencer
//
// Ports:
//   ref_clk, rst                  clock, asynchronous active-high reset
//   en_req                        level request: 1 = FLB running, 0 = off
//   cfg_apply                     one-cycle pulse committing the cfg_* inputs
//   cfg_mtrx_lag, cfg_smpl_lag    requested clock lags
//   cfg_sdm_order, cfg_sdm_thrm_en requested SDM order / thermometer enable
//   csr_flb_en .. csr_dec_en      ordered datapath enables
//   csr_flb_*                     shadowed configuration
//   ready                         high only in RUN
//   busy                          high outside IDLE and RUN
//   cfg_ack                       one-cycle pulse as the shadow loads
//   state_o                       current state (debug)
module flb_seq_ctrl
    import flb_ctrl_pkg::*;
#(
    parameter int T_FLB  = T_FLB_DEF,
    parameter int T_SYNC = T_SYNC_DEF,
    parameter int T_SDM  = T_SDM_DEF,
    parameter int T_DEC  = T_DEC_DEF,
    parameter int T_DN   = T_DN_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic       ref_clk,
    input  logic       rst,
    input  logic       en_req,
    input  logic       cfg_apply,
    input  logic [1:0] cfg_mtrx_lag,
    input  logic [1:0] cfg_smpl_lag,
    input  logic       cfg_sdm_order,
    input  logic       cfg_sdm_thrm_en,
    output logic       csr_flb_en,
    output logic       csr_sync_en,
    output logic       csr_flb_sdm_en,
    output logic       csr_dec_en,
    output logic [1:0] csr_flb_mtrx_clk_lag,
    output logic [1:0] csr_flb_smpl_clk_lag,
    output logic       csr_flb_sdm_order,
    output logic       csr_flb_sdm_thrm_en,
    output logic       ready,
    output logic       busy,
    output logic       cfg_ack,
    output logic [3:0] state_o
);

    flb_seq_state_e   r_state;
    flb_seq_state_e   w_nxt_state;
    logic             w_state_chg;
    logic             w_expired;
    logic [CNT_W-1:0] w_tmr_val;
    flb_cfg_t         w_cfg_in;

    flb_cfg_t         r_shadow;
    flb_cfg_t         r_pend_cfg;
    logic             r_cfg_pend;
    logic             r_reconf;
    logic             r_flb_en;
    logic             r_sync_en;
    logic             r_sdm_en;
    logic             r_dec_en;
    logic             r_ready;
    logic             r_busy;
    logic             r_cfg_ack;

    assign w_cfg_in = {cfg_mtrx_lag, cfg_smpl_lag, cfg_sdm_order, cfg_sdm_thrm_en};

    // Next-state decision. Kept combinational so the settle timer can be
    // loaded on the same edge that enters a state.
    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            S_IDLE:    if (en_req) w_nxt_state = S_UP_FLB;
            // A dropped request leaves the UP chain through the DN state of
            // the highest stage already enabled.
            S_UP_FLB:  if (!en_req) w_nxt_state = S_DN_FLB;
                       else if (w_expired) w_nxt_state = S_UP_SYNC;
            S_UP_SYNC: if (!en_req) w_nxt_state = S_DN_SYNC;
                       else if (w_expired) w_nxt_state = S_UP_SDM;
            S_UP_SDM:  if (!en_req) w_nxt_state = S_DN_SDM;
                       else if (w_expired) w_nxt_state = S_UP_DEC;
            S_UP_DEC:  if (!en_req) w_nxt_state = S_DN_DEC;
                       else if (w_expired) w_nxt_state = S_RUN;
            S_RUN:     if (!en_req || cfg_apply || r_cfg_pend) w_nxt_state = S_DN_DEC;
            S_DN_DEC:  if (w_expired) w_nxt_state = S_DN_SDM;
            S_DN_SDM:  if (w_expired) w_nxt_state = S_DN_SYNC;
            // Reconfiguration keeps csr_flb_en up and detours through APPLY;
            // a dropped request always wins and completes the power-down.
            S_DN_SYNC: if (w_expired) w_nxt_state = (r_reconf && en_req) ? S_APPLY : S_DN_FLB;
            S_DN_FLB:  if (w_expired) w_nxt_state = S_IDLE;
            S_APPLY:   w_nxt_state = en_req ? S_UP_SYNC : S_DN_FLB;
            default:   w_nxt_state = S_IDLE;
        endcase
    end

    assign w_state_chg = (w_nxt_state != r_state);

    always_comb begin
        w_tmr_val = '0;
        case (w_nxt_state)
            S_UP_FLB:  w_tmr_val = CNT_W'(T_FLB - 1);
            S_UP_SYNC: w_tmr_val = CNT_W'(T_SYNC - 1);
            S_UP_SDM:  w_tmr_val = CNT_W'(T_SDM - 1);
            S_UP_DEC:  w_tmr_val = CNT_W'(T_DEC - 1);
            S_DN_DEC, S_DN_SDM, S_DN_SYNC, S_DN_FLB:
                       w_tmr_val = CNT_W'(T_DN - 1);
            default:   w_tmr_val = '0;
        endcase
    end

    flb_settle_timer #(
        .CNT_W (CNT_W)
    ) u_settle_timer (
        .ref_clk  (ref_clk),
        .rst      (rst),
        .load     (w_state_chg),
        .load_val (w_tmr_val),
        .expired  (w_expired)
    );

    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shadow   <= '0;
            r_pend_cfg <= '0;
            r_cfg_pend <= 1'b0;
            r_reconf   <= 1'b0;
            r_flb_en   <= 1'b0;
            r_sync_en  <= 1'b0;
            r_sdm_en   <= 1'b0;
            r_dec_en   <= 1'b0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_cfg_ack  <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_ready   <= (w_nxt_state == S_RUN);
            r_busy    <= (w_nxt_state != S_IDLE) && (w_nxt_state != S_RUN);
            r_cfg_ack <= 1'b0;

            if (w_state_chg) begin
                case (w_nxt_state)
                    S_UP_FLB:  r_flb_en  <= 1'b1;
                    S_UP_SYNC: r_sync_en <= 1'b1;
                    S_UP_SDM:  r_sdm_en  <= 1'b1;
                    S_UP_DEC:  r_dec_en  <= 1'b1;
                    S_DN_DEC:  r_dec_en  <= 1'b0;
                    S_DN_SDM:  r_sdm_en  <= 1'b0;
                    S_DN_SYNC: r_sync_en <= 1'b0;
                    S_DN_FLB:  r_flb_en  <= 1'b0;
                    S_APPLY:   r_cfg_ack <= 1'b1;
                    default:   ;
                endcase
            end

            // r_reconf marks a DN chain entered for reconfiguration; any
            // cycle with en_req low turns it into a full power-down.
            if (r_state == S_RUN && w_state_chg) begin
                r_reconf <= en_req;
            end else if (!en_req) begin
                r_reconf <= 1'b0;
            end

            // Shadow load / pending request bookkeeping. The latest
            // cfg_apply is the one that lands.
            if (r_state == S_IDLE) begin
                if (cfg_apply) begin
                    r_shadow  <= w_cfg_in;
                    r_cfg_ack <= 1'b1;
                end
            end else if (w_state_chg && w_nxt_state == S_IDLE) begin
                if (cfg_apply || r_cfg_pend) begin
                    r_shadow   <= cfg_apply ? w_cfg_in : r_pend_cfg;
                    r_cfg_ack  <= 1'b1;
                    r_cfg_pend <= 1'b0;
                end
            end else if (r_state == S_APPLY) begin
                r_shadow   <= r_pend_cfg;
                r_cfg_pend <= cfg_apply;
                if (cfg_apply) r_pend_cfg <= w_cfg_in;
            end else if (cfg_apply) begin
                r_cfg_pend <= 1'b1;
                r_pend_cfg <= w_cfg_in;
            end
        end
    end

    assign csr_flb_en           = r_flb_en;
    assign csr_sync_en          = r_sync_en;
    assign csr_flb_sdm_en       = r_sdm_en;
    assign csr_dec_en           = r_dec_en;
    assign csr_flb_mtrx_clk_lag = r_shadow.mtrx_lag;
    assign csr_flb_smpl_clk_lag = r_shadow.smpl_lag;
    assign csr_flb_sdm_order    = r_shadow.sdm_order;
    assign csr_flb_sdm_thrm_en  = r_shadow.sdm_thrm_en;
    assign ready                = r_ready;
    assign busy                 = r_busy;
    assign cfg_ack              = r_cfg_ack;
    assign state_o              = r_state;

endmodule

// File: tb/tb_flb_seq_ctrl.sv
// tb/tb_flb_seq_ctrl.sv - self-checking bench for flb_seq_ctrl
module tb_flb_seq_ctrl;
    import flb_ctrl_pkg::*;

    logic       ref_clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_req = 1'b0;
    logic       cfg_apply = 1'b0;
    logic [1:0] cfg_mtrx_lag = 2'd0;
    logic [1:0] cfg_smpl_lag = 2'd0;
    logic       cfg_sdm_order = 1'b0;
    logic       cfg_sdm_thrm_en = 1'b0;
    logic       csr_flb_en, csr_sync_en, csr_flb_sdm_en, csr_dec_en;
    logic [1:0] csr_flb_mtrx_clk_lag, csr_flb_smpl_clk_lag;
    logic       csr_flb_sdm_order, csr_flb_sdm_thrm_en;
    logic       ready, busy, cfg_ack;
    logic [3:0] state_o;

    flb_seq_ctrl dut (
        .ref_clk              (ref_clk),
        .rst                  (rst),
        .en_req               (en_req),
        .cfg_apply            (cfg_apply),
        .cfg_mtrx_lag         (cfg_mtrx_lag),
        .cfg_smpl_lag         (cfg_smpl_lag),
        .cfg_sdm_order        (cfg_sdm_order),
        .cfg_sdm_thrm_en      (cfg_sdm_thrm_en),
        .csr_flb_en           (csr_flb_en),
        .csr_sync_en          (csr_sync_en),
        .csr_flb_sdm_en       (csr_flb_sdm_en),
        .csr_dec_en           (csr_dec_en),
        .csr_flb_mtrx_clk_lag (csr_flb_mtrx_clk_lag),
        .csr_flb_smpl_clk_lag (csr_flb_smpl_clk_lag),
        .csr_flb_sdm_order    (csr_flb_sdm_order),
        .csr_flb_sdm_thrm_en  (csr_flb_sdm_thrm_en),
        .ready                (ready),
        .busy                 (busy),
        .cfg_ack              (cfg_ack),
        .state_o              (state_o)
    );

    always #5 ref_clk = ~ref_clk;

    localparam int F_FLB = 0, F_SYNC = 1, F_SDM = 2, F_DEC = 3, F_READY = 4, F_BUSY = 5;
    localparam int F_ACK = 6, F_STATE = 7, F_MTRX = 8, F_SMPL = 9, F_ORD = 10, F_THRM = 11;

    typedef struct {
        int         cyc;
        int         fld;
        logic [3:0] val;
        string      tag;
    } sb_item_t;

    sb_item_t sb_q[$];
    int cyc = 0;
    int base = 0;
    int n_chk = 0;
    int n_fail = 0;

    always @(posedge ref_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic logic [3:0] obs(input int f);
        case (f)
            F_FLB:   return {3'b0, csr_flb_en};
            F_SYNC:  return {3'b0, csr_sync_en};
            F_SDM:   return {3'b0, csr_flb_sdm_en};
            F_DEC:   return {3'b0, csr_dec_en};
            F_READY: return {3'b0, ready};
            F_BUSY:  return {3'b0, busy};
            F_ACK:   return {3'b0, cfg_ack};
            F_STATE: return state_o;
            F_MTRX:  return {2'b0, csr_flb_mtrx_clk_lag};
            F_SMPL:  return {2'b0, csr_flb_smpl_clk_lag};
            F_ORD:   return {3'b0, csr_flb_sdm_order};
            F_THRM:  return {3'b0, csr_flb_sdm_thrm_en};
            default: return 4'hx;
        endcase
    endfunction

    // Expectations are keyed to a cycle offset from the current stimulus base.
    task automatic exp_at(input int rel, input int fld, input int val, input string tag);
        sb_item_t it;
        it.cyc = base + rel;
        it.fld = fld;
        it.val = 4'(val);
        it.tag = $sformatf("%s@%0d", tag, rel);
        sb_q.push_back(it);
    endtask

    task automatic exp_rng(input int r0, input int r1, input int fld, input int val, input string tag);
        for (int r = r0; r <= r1; r++) exp_at(r, fld, val, tag);
    endtask

    // Pops every expectation due this cycle and compares it to the DUT.
    always @(negedge ref_clk) begin
        sb_item_t keep[$];
        keep = {};
        foreach (sb_q[i]) begin
            if (sb_q[i].cyc == cyc) chk(sb_q[i].tag, 32'(obs(sb_q[i].fld)), 32'(sb_q[i].val));
            else keep.push_back(sb_q[i]);
        end
        sb_q = keep;
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge ref_clk);
    endtask

    task automatic set_cfg(input int mtrx, input int smpl, input int ord, input int thrm);
        cfg_mtrx_lag    = 2'(mtrx);
        cfg_smpl_lag    = 2'(smpl);
        cfg_sdm_order   = 1'(ord);
        cfg_sdm_thrm_en = 1'(thrm);
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_flb"}, 32'(csr_flb_en), 0);
        chk({pfx, "_sync"}, 32'(csr_sync_en), 0);
        chk({pfx, "_sdm"}, 32'(csr_flb_sdm_en), 0);
        chk({pfx, "_dec"}, 32'(csr_dec_en), 0);
        chk({pfx, "_ready"}, 32'(ready), 0);
        chk({pfx, "_busy"}, 32'(busy), 0);
        chk({pfx, "_ack"}, 32'(cfg_ack), 0);
        chk({pfx, "_state"}, 32'(state_o), 32'(S_IDLE));
        chk({pfx, "_shadow"}, {26'b0, csr_flb_mtrx_clk_lag, csr_flb_smpl_clk_lag,
                               csr_flb_sdm_order, csr_flb_sdm_thrm_en}, 0);
    endtask

    initial begin
        wait_n(2);
        chk_all_zero("reset");
        rst = 1'b0;
        wait_n(1);

        // Config load while idle: immediate, no sequencing.
        base = cyc;
        set_cfg(1, 2, 1, 1);
        cfg_apply = 1'b1;
        exp_at(1, F_ACK, 1, "idle_ack");
        exp_at(2, F_ACK, 0, "idle_ack_clr");
        exp_at(1, F_MTRX, 1, "idle_mtrx");
        exp_at(1, F_SMPL, 2, "idle_smpl");
        exp_at(1, F_ORD, 1, "idle_ord");
        exp_at(1, F_THRM, 1, "idle_thrm");
        exp_at(1, F_STATE, S_IDLE, "idle_state");
        exp_at(1, F_BUSY, 0, "idle_busy");
        wait_n(1);
        cfg_apply = 1'b0;
        wait_n(2);

        // Bring-up.
        base = cyc;
        en_req = 1'b1;
        exp_at(1, F_FLB, 1, "up_flb");
        exp_at(1, F_STATE, S_UP_FLB, "up_state_flb");
        exp_at(1, F_BUSY, 1, "up_busy");
        exp_at(4, F_SYNC, 0, "up_sync_early");
        exp_at(5, F_SYNC, 1, "up_sync");
        exp_at(12, F_SDM, 0, "up_sdm_early");
        exp_at(13, F_SDM, 1, "up_sdm");
        exp_at(16, F_DEC, 0, "up_dec_early");
        exp_at(17, F_DEC, 1, "up_dec");
        exp_at(18, F_READY, 0, "up_ready_early");
        exp_at(19, F_READY, 1, "up_ready");
        exp_at(19, F_STATE, S_RUN, "up_state_run");
        exp_at(19, F_BUSY, 0, "up_busy_run");
        exp_at(19, F_MTRX, 1, "up_mtrx_kept");
        wait_n(22);

        // Reconfiguration from RUN.
        base = cyc;
        set_cfg(2, 1, 0, 0);
        cfg_apply = 1'b1;
        exp_at(1, F_DEC, 0, "rc_dec");
        exp_at(3, F_SDM, 0, "rc_sdm");
        exp_at(5, F_SYNC, 0, "rc_sync");
        exp_at(6, F_ACK, 0, "rc_ack_early");
        exp_at(7, F_ACK, 1, "rc_ack");
        exp_at(8, F_ACK, 0, "rc_ack_clr");
        exp_at(7, F_STATE, S_APPLY, "rc_state_apply");
        exp_at(7, F_MTRX, 1, "rc_mtrx_old");
        exp_at(8, F_MTRX, 2, "rc_mtrx_new");
        exp_at(7, F_SMPL, 2, "rc_smpl_old");
        exp_at(8, F_SMPL, 1, "rc_smpl_new");
        exp_at(7, F_ORD, 1, "rc_ord_old");
        exp_at(8, F_ORD, 0, "rc_ord_new");
        exp_at(8, F_SYNC, 1, "rc_sync_up");
        exp_rng(1, 22, F_FLB, 1, "rc_flb_held");
        exp_at(21, F_READY, 0, "rc_ready_early");
        exp_at(22, F_READY, 1, "rc_ready");
        wait_n(1);
        cfg_apply = 1'b0;
        wait_n(24);

        // Power-down from RUN.
        base = cyc;
        en_req = 1'b0;
        exp_at(1, F_DEC, 0, "dn_dec");
        exp_at(1, F_READY, 0, "dn_ready");
        exp_at(2, F_SDM, 1, "dn_sdm_early");
        exp_at(3, F_SDM, 0, "dn_sdm");
        exp_at(4, F_SYNC, 1, "dn_sync_early");
        exp_at(5, F_SYNC, 0, "dn_sync");
        exp_at(6, F_FLB, 1, "dn_flb_early");
        exp_at(7, F_FLB, 0, "dn_flb");
        exp_rng(1, 8, F_BUSY, 1, "dn_busy");
        exp_at(9, F_BUSY, 0, "dn_busy_clr");
        exp_at(9, F_STATE, S_IDLE, "dn_idle");
        wait_n(11);

        // Abort during UP_SDM.
        base = cyc;
        en_req = 1'b1;
        exp_rng(1, 14, F_DEC, 0, "ab_dec_pre");
        wait_n(14);
        base = cyc;
        en_req = 1'b0;
        exp_at(1, F_SDM, 0, "ab_sdm");
        exp_at(1, F_STATE, S_DN_SDM, "ab_state_dn_sdm");
        exp_at(2, F_SYNC, 1, "ab_sync_early");
        exp_at(3, F_SYNC, 0, "ab_sync");
        exp_at(4, F_FLB, 1, "ab_flb_early");
        exp_at(5, F_FLB, 0, "ab_flb");
        exp_at(6, F_BUSY, 1, "ab_busy");
        exp_at(7, F_BUSY, 0, "ab_busy_clr");
        exp_at(7, F_STATE, S_IDLE, "ab_idle");
        exp_rng(1, 8, F_DEC, 0, "ab_dec_post");
        wait_n(10);

        // cfg_apply during UP_SYNC is deferred to RUN, then async reset mid DN chain.
        base = cyc;
        en_req = 1'b1;
        exp_rng(1, 26, F_SMPL, 1, "pd_smpl_old");
        exp_at(27, F_SMPL, 3, "pd_smpl_new");
        exp_at(27, F_MTRX, 2, "pd_mtrx");
        exp_at(19, F_READY, 1, "pd_ready");
        exp_at(20, F_READY, 0, "pd_ready_drop");
        exp_at(25, F_ACK, 0, "pd_ack_early");
        exp_at(26, F_ACK, 1, "pd_ack");
        exp_at(27, F_ACK, 0, "pd_ack_clr");
        exp_at(26, F_STATE, S_APPLY, "pd_state_apply");
        exp_rng(1, 41, F_FLB, 1, "pd_flb_held");
        exp_at(41, F_READY, 1, "pd_ready2");
        wait_n(6);
        set_cfg(2, 3, 0, 0);
        cfg_apply = 1'b1;
        wait_n(1);
        cfg_apply = 1'b0;
        wait_n(35);
        en_req = 1'b0;
        wait_n(3);
        chk("rst_pre_state", 32'(state_o), 32'(S_DN_SDM));
        chk("rst_pre_flb", 32'(csr_flb_en), 1);
        chk("rst_pre_sync", 32'(csr_sync_en), 1);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        wait_n(2);
        rst = 1'b0;
        wait_n(2);
        chk("post_rst_state", 32'(state_o), 32'(S_IDLE));
        chk("sb_empty", 32'(sb_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/flb_seq_ctrl.md
Name: flb_seq_ctrl

Overview:
Power-up, power-down and reconfiguration sequencer for the FLB datapath, running in the ref_clk domain.
- Drives the FLB enables in a fixed order: csr_flb_en, then csr_sync_en, then csr_flb_sdm_en, then csr_dec_en. Each step waits its own settle time.
- Owns the shadowed FLB configuration: clock lags, SDM order and thermometer enable.
- Config changes take effect only while the datapath is quiesced, so SYNC, SDM and DEC never see a lag change while enabled.

Parameters:
T_FLB, 4, settle cycles after csr_flb_en rises (covers the 2-flop sync and latch in the clock gate)
T_SYNC, 8, settle cycles after csr_sync_en rises
T_SDM, 4, settle cycles after csr_flb_sdm_en rises
T_DEC, 2, settle cycles after csr_dec_en rises
T_DN, 2, settle cycles for each power-down step
CNT_W, 8, settle counter width; every T_* must be in 1..2^CNT_W-1

Ports:
ref_clk  in  1  block clock
rst  in  1  reset, asynchronous, active-high
en_req  in  1  level request; 1 = FLB running, 0 = FLB off
cfg_apply  in  1  one-cycle pulse: commit the cfg_* inputs
cfg_mtrx_lag  in  2  requested matrix clock lag
cfg_smpl_lag  in  2  requested sample clock lag
cfg_sdm_order  in  1  requested SDM order
cfg_sdm_thrm_en  in  1  requested SDM thermometer enable
csr_flb_en  out  1  FLB master enable (active-high)
csr_sync_en  out  1  SYNC enable
csr_flb_sdm_en  out  1  SDM enable
csr_dec_en  out  1  DEC enable
csr_flb_mtrx_clk_lag  out  2  shadowed matrix lag
csr_flb_smpl_clk_lag  out  2  shadowed sample lag
csr_flb_sdm_order  out  1  shadowed SDM order
csr_flb_sdm_thrm_en  out  1  shadowed thermometer enable
ready  out  1  high only in RUN
busy  out  1  high in any state other than IDLE or RUN
cfg_ack  out  1  one-cycle pulse when the shadow registers load
state_o  out  4  current FSM state, for debug

Behaviour:
- Clock and reset:
  - Single clock ref_clk; rst is asynchronous, active-high.
  - Reset values: all outputs 0, shadow registers 0, state IDLE, cfg_pend 0.
  - rst asserted mid-sequence drops every enable in the same instant, with no ordered shutdown.
- States: IDLE, UP_FLB, UP_SYNC, UP_SDM, UP_DEC, RUN, DN_DEC, DN_SDM, DN_SYNC, DN_FLB, APPLY.
- Outputs:
  - All outputs are registered and change only on the cycle a state is entered.
  - Entering a UP_x state sets its enable; entering a DN_x state clears its enable.
- Settle timer:
  - Loads T_x-1 on state entry and decrements each cycle.
  - The state exits on the cycle the count reads 0, so each UP_x/DN_x state lasts exactly T_x cycles.
- Transitions:
  - IDLE to UP_FLB when en_req=1.
  - The UP chain runs UP_FLB, UP_SYNC, UP_SDM, UP_DEC, then RUN.
  - RUN to DN_DEC when en_req=0, or when a cfg_apply pulse or cfg_pend is seen.
  - The DN chain runs DN_DEC, DN_SDM, DN_SYNC, then DN_FLB and IDLE when the exit is caused by en_req=0.
  - When the exit is for reconfiguration, DN_SYNC goes to APPLY instead, and csr_flb_en stays high.
  - APPLY lasts 1 cycle: the shadow loads from cfg_*, cfg_ack=1, cfg_pend clears, then UP_SYNC (or DN_FLB if en_req=0).
- en_req dropping during the UP chain: jump directly to the DN state of the highest stage currently enabled. For example, UP_SDM goes to DN_SDM and UP_FLB goes to DN_FLB.
- en_req rising during the DN chain: the power-down completes to IDLE, then a normal restart follows. There is no abort.
- cfg_apply by state:
  - In IDLE: the shadow loads on the next edge and cfg_ack pulses; no sequencing.
  - In any UP, DN or APPLY state: set cfg_pend. It is serviced on reaching RUN, or discarded-and-loaded when IDLE is reached.
- Priority: en_req=0 takes precedence over reconfiguration. A reconfig that is in flight in the DN chain exits via DN_FLB to IDLE, and the pending config loads in IDLE.
- Shadow outputs are stable at all times except the APPLY edge. During APPLY, csr_sync_en, csr_flb_sdm_en and csr_dec_en are guaranteed 0.

Decomposition:
- Package flb_ctrl_pkg contains:
  - the state enum flb_seq_state_e (4-bit encoding);
  - the T_* default localparams;
  - the struct flb_cfg_t bundling the lags, order and thrm_en.
- Sub-module flb_settle_timer: a loadable down-counter with load, load_val[CNT_W-1:0] and expired outputs, instantiated once.

Test Plan:
- Bring-up: rst released, en_req=1 sampled at cycle 0. Expect csr_flb_en=1 at cycle 1, sync_en at 5, sdm_en at 13, dec_en at 17, ready at 19 (defaults).
- Power-down from RUN: en_req=0 at cycle 0. Expect dec_en=0 at 1, sdm_en=0 at 3, sync_en=0 at 5, flb_en=0 at 7, state IDLE at 9, busy cycles 1-8.
- Reconfig in RUN: cfg_apply with mtrx_lag=2, smpl_lag=1 at cycle 0.
  - Expect enables to drop at 1, 3 and 5; cfg_ack at 7; csr_flb_mtrx_clk_lag=2 from 8; flb_en continuously 1; ready again at 22.
- Abort mid bring-up: en_req drops while in UP_SDM (cycle 14). Expect sdm_en=0 next cycle, then sync_en=0 and flb_en=0 in order, ending in IDLE.
  - dec_en is never asserted.
- cfg_apply during UP_SYNC with smpl_lag=3. Expect the shadow unchanged through bring-up, RUN reached, then an immediate reconfig loop and cfg_ack. Additionally assert rst mid-DN chain and check that all outputs go to 0 asynchronously.
